// File: rtl/misc_v_pkg.sv
// Shared opcode constants, instruction field positions and fetch FSM states.
package misc_v_pkg;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned OPCODE_W   = 3;
  localparam int unsigned FUNC_W     = 4;
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 13;
  localparam int unsigned FUNC_MSB   = 3;
  localparam int unsigned FUNC_LSB   = 0;

  localparam logic [OPCODE_W-1:0] OP_R    = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_I    = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_LW   = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_SW   = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_BR0  = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_BR1  = 3'd5;
  localparam logic [OPCODE_W-1:0] OP_JIN  = 3'd6;
  localparam logic [OPCODE_W-1:0] OP_JOUT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: register jump, jump-in, taken branch, else sequential.
module pc_next
  import misc_v_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic [PC_W-1:0]     pc_cur,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                branch,
  input  logic                jump_out,
  input  logic                br_taken,
  input  logic [PC_W-1:0]     br_target,
  input  logic [PC_W-1:0]     jr_target,
  output logic [PC_W-1:0]     pc_nxt
);

  // Priority mux; the increment wraps silently at the top of the address space.
  always_comb begin
    pc_nxt = pc_cur + PC_W'(1);
    if (branch && jump_out) begin
      pc_nxt = jr_target;
    end else if (branch && (opcode == OP_JIN)) begin
      pc_nxt = br_target;
    end else if (branch && br_taken) begin
      pc_nxt = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: request/ack handshake to instruction memory, holds the
// fetched word while stalled and selects the next PC on release.
module instr_fetch
  import misc_v_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                Branch,
  input  logic                JumpOut,
  input  logic                br_taken,
  input  logic [PC_W-1:0]     br_target,
  input  logic [PC_W-1:0]     jr_target,
  output logic                instr_valid,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNC_W-1:0]   func,
  output logic [INSTR_W-1:0]  instr,
  output logic [PC_W-1:0]     pc_out
);

  fetch_state_t         state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 req_q, req_d;
  logic                 valid_q, valid_d;
  logic                 load_instr;
  logic [INSTR_W-1:0]   instr_q;
  logic [PC_W-1:0]      pc_out_q;
  logic [PC_W-1:0]      pc_redirect;

  pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc_cur    (pc_out_q),
    .opcode    (instr_q[OPCODE_MSB:OPCODE_LSB]),
    .branch    (Branch),
    .jump_out  (JumpOut),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jr_target (jr_target),
    .pc_nxt    (pc_redirect)
  );

  // Next state, next PC and next registered handshake/valid flags.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load_instr = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          state_d    = HOLD;
          load_instr = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_d = REQ;
          pc_d    = pc_redirect;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d   = (state_d == REQ);
    valid_d = (state_d == HOLD);
  end

  // State, PC and control flags; reset drops the request immediately.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  // Capture the acknowledged word and its address; held otherwise.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      instr_q  <= '0;
      pc_out_q <= '0;
    end else if (load_instr) begin
      instr_q  <= imem_rdata;
      pc_out_q <= pc_q;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign func        = instr_q[FUNC_MSB:FUNC_LSB];
  assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table of fetches plus stall and reset sequences.
module tb_instr_fetch;

  logic        CLK;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        Branch;
  logic        JumpOut;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] jr_target;
  logic        instr_valid;
  logic [2:0]  opcode;
  logic [3:0]  func;
  logic [15:0] instr;
  logic [15:0] pc_out;

  int n_checks;
  int n_fail;

  instr_fetch #(
    .PC_W     (16),
    .RESET_PC (16'h0000)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .Branch      (Branch),
    .JumpOut     (JumpOut),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jr_target   (jr_target),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .func        (func),
    .instr       (instr),
    .pc_out      (pc_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] rdata;
    logic        br;
    logic        jo;
    logic        bt;
    logic [15:0] brt;
    logic [15:0] jrt;
    logic [15:0] nxt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_ctl();
    Branch    = 1'b0;
    JumpOut   = 1'b0;
    br_taken  = 1'b0;
    br_target = 16'h0000;
    jr_target = 16'h0000;
  endtask

  // One full fetch: called at a negedge with a request outstanding.
  task automatic run_vec(input vec_t v);
    logic [15:0] w;
    w = v.rdata;
    chk("req_up", 32'(imem_req), 32'd1);
    chk("addr", 32'(imem_addr), 32'(v.addr));
    chk("valid_in_req", 32'(instr_valid), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    @(negedge CLK);
    imem_ack = 1'b0;
    chk("valid_hold", 32'(instr_valid), 32'd1);
    chk("req_hold", 32'(imem_req), 32'd0);
    chk("instr", 32'(instr), 32'(v.rdata));
    chk("opcode", 32'(opcode), 32'(w[15:13]));
    chk("func", 32'(func), 32'(w[3:0]));
    chk("pc_out", 32'(pc_out), 32'(v.addr));
    Branch    = v.br;
    JumpOut   = v.jo;
    br_taken  = v.bt;
    br_target = v.brt;
    jr_target = v.jrt;
    @(negedge CLK);
    clear_ctl();
    chk("next_req", 32'(imem_req), 32'd1);
    chk("next_addr", 32'(imem_addr), 32'(v.nxt));
    chk("valid_drop", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    stall      = 1'b0;
    clear_ctl();

    //             addr      rdata     br    jo    bt    brt       jrt       nxt
    vecs[0]  = '{16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001};
    vecs[1]  = '{16'h0001, 16'h2005, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0002};
    vecs[2]  = '{16'h0002, 16'h4000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0003};
    vecs[3]  = '{16'h0003, 16'h8003, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0040};
    vecs[4]  = '{16'h0040, 16'h8003, 1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000, 16'h0041};
    vecs[5]  = '{16'h0041, 16'hE000, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h1234, 16'h1234};
    vecs[6]  = '{16'h1234, 16'hC000, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'h0200};
    vecs[7]  = '{16'h0200, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0300, 16'h0000, 16'h0201};
    vecs[8]  = '{16'h0201, 16'hE00F, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[9]  = '{16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[10] = '{16'h0000, 16'hA00C, 1'b1, 1'b0, 1'b1, 16'h0050, 16'h0000, 16'h0050};
    vecs[11] = '{16'h0050, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h9999, 16'h0051};

    // Reset state.
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h0000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_func", 32'(func), 32'd0);

    reset = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i]);
    end

    // Stall for 3 cycles with Branch toggling; release with Branch=0.
    chk("st_addr", 32'(imem_addr), 32'h0051);
    imem_ack   = 1'b1;
    imem_rdata = 16'h8003;
    @(negedge CLK);
    imem_ack  = 1'b0;
    stall     = 1'b1;
    br_taken  = 1'b1;
    br_target = 16'h0777;
    for (int i = 0; i < 3; i++) begin
      Branch = ~Branch;
      @(negedge CLK);
      chk("st_valid", 32'(instr_valid), 32'd1);
      chk("st_req", 32'(imem_req), 32'd0);
      chk("st_instr", 32'(instr), 32'h8003);
      chk("st_pc_out", 32'(pc_out), 32'h0051);
    end
    stall  = 1'b0;
    Branch = 1'b0;
    @(negedge CLK);
    clear_ctl();
    chk("st_rel_req", 32'(imem_req), 32'd1);
    chk("st_rel_addr", 32'(imem_addr), 32'h0052);

    // Stall then release with Branch=1 taken: redirect uses release-cycle value.
    imem_ack   = 1'b1;
    imem_rdata = 16'hA001;
    @(negedge CLK);
    imem_ack  = 1'b0;
    stall     = 1'b1;
    Branch    = 1'b0;
    br_taken  = 1'b1;
    br_target = 16'h0123;
    @(negedge CLK);
    chk("st2_req", 32'(imem_req), 32'd0);
    stall  = 1'b0;
    Branch = 1'b1;
    @(negedge CLK);
    clear_ctl();
    chk("st2_addr", 32'(imem_addr), 32'h0123);

    // Reset while a request is outstanding; late ack must be ignored.
    chk("mr_req_before", 32'(imem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_req_now", 32'(imem_req), 32'd0);
    chk("mr_addr_now", 32'(imem_addr), 32'h0000);
    chk("mr_valid_now", 32'(instr_valid), 32'd0);
    chk("mr_instr_now", 32'(instr), 32'd0);
    @(negedge CLK);
    imem_ack   = 1'b1;
    imem_rdata = 16'hDEAD;
    @(negedge CLK);
    imem_ack = 1'b0;
    chk("mr_ack_req", 32'(imem_req), 32'd0);
    chk("mr_ack_valid", 32'(instr_valid), 32'd0);
    chk("mr_ack_instr", 32'(instr), 32'd0);
    reset = 1'b1;
    @(negedge CLK);
    run_vec('{16'h0000, 16'h6007, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL give the first fetch address after reset.
REQ-002 Parameter PC_W, default 16, SHALL give the PC and instruction-memory address width; instruction width is fixed at 16.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be asynchronous and active-low: 0 resets immediately, independent of CLK.
REQ-005 imem_req  out  1  SHALL request the word at imem_addr.
REQ-006 imem_addr  out  PC_W  SHALL give the word address of the current fetch.
REQ-007 imem_ack  in  1  SHALL mark imem_rdata valid for the outstanding request.
REQ-008 imem_rdata  in  16  SHALL carry the fetched instruction word.
REQ-009 stall  in  1  SHALL hold the current instruction in place while 1.
REQ-010 Branch  in  1  SHALL be the redirect flag returned by the control decoder.
REQ-011 JumpOut  in  1  SHALL select the register-indirect jump target.
REQ-012 br_taken  in  1  SHALL be the ALU branch-condition result for the current instruction.
REQ-013 br_target  in  PC_W  SHALL be the PC-relative branch or jump-in target.
REQ-014 jr_target  in  PC_W  SHALL be the register jump-out target.
REQ-015 instr_valid  out  1  SHALL mark opcode/func/instr/pc_out as a live instruction.
REQ-016 opcode  out  3  SHALL carry instr[15:13].
REQ-017 func  out  4  SHALL carry instr[3:0].
REQ-018 instr  out  16  SHALL carry the full registered instruction word.
REQ-019 pc_out  out  PC_W  SHALL carry the address of the instruction on instr.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ and HOLD, with the following transitions:
- IDLE->REQ unconditionally on the first edge after reset release.
- REQ->HOLD on imem_ack.
- HOLD->REQ when stall=0.
REQ-021 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; in IDLE and HOLD, imem_req SHALL be 0.
REQ-022 imem_ack SHALL be ignored outside REQ.
REQ-023 An ack at edge N SHALL register instr, opcode, func and pc_out, and SHALL assert instr_valid from edge N, giving one-cycle latency from ack to a visible instruction.
REQ-024 In HOLD, instr_valid SHALL be 1; in IDLE and REQ it SHALL be 0.
REQ-025 opcode, func, instr and pc_out SHALL hold their last value when instr_valid=0, and consumers SHALL gate on instr_valid.
REQ-026 On leaving HOLD (stall=0), the next pc SHALL be chosen in priority order:
- Branch&JumpOut: jr_target.
- Branch&opcode==JUMP_IN: br_target.
- Branch&br_taken: br_target.
- Otherwise: pc_out+1.
REQ-027 While stall=1, HOLD SHALL persist and every output SHALL hold, with no redirect taken; Branch and targets SHALL be sampled only on the releasing edge.
REQ-028 pc+1 at 16'hFFFF SHALL wrap to 16'h0000 with no flag.
REQ-029 An ack arriving on the same edge that the request is dropped SHALL NOT occur by construction, since imem_req drops only after ack.

Reset
REQ-030 While reset=0, the block SHALL hold:
- state=IDLE and pc=RESET_PC.
- imem_req=0, imem_addr=RESET_PC.
- instr_valid=0.
- opcode=0, func=0, instr=0, pc_out=0.
REQ-031 Reset asserted mid-REQ SHALL drop imem_req immediately and discard the outstanding fetch; a late ack SHALL be ignored.
REQ-032 The first request after release SHALL issue at RESET_PC on the first CLK edge.

Structure
REQ-033 Package misc_v_pkg SHALL hold:
- The opcode constants OP_R=0, OP_I=1, OP_LW=2, OP_SW=3, OP_BR0=4, OP_BR1=5, OP_JIN=6, OP_JOUT=7.
- The instruction field positions.
- The fetch-state enum.
REQ-034 Sub-module pc_next SHALL be combinational and SHALL implement the REQ-026 priority mux and the incrementer.

Verification
REQ-035 Release reset with RESET_PC=0 and ack one cycle after each req, with no stall and no Branch -> imem_addr goes 0,1,2,3, and each instr_valid pulse shows pc_out equal to the fetched address.
REQ-036 Fetch word 16'h8003 (opcode 4, func 3) with Branch=1, br_taken=1, br_target=16'h0040 -> next imem_addr=16'h0040; the same case with br_taken=0 -> pc_out+1.
REQ-037 Fetch opcode 7 with Branch=1, JumpOut=1, jr_target=16'h1234, br_target=16'h0040 -> next imem_addr=16'h1234.
REQ-038 Hold stall=1 for 3 cycles while Branch toggles -> instr, pc_out and instr_valid are unchanged and imem_req=0; on release, redirect follows the Branch value of the release cycle only.
REQ-039 Set pc=16'hFFFF with no Branch -> next imem_addr=16'h0000.
REQ-040 Drive reset low while imem_req=1, then ack 1 cycle later -> imem_req falls without waiting for a clock edge, the ack is ignored, and after release the fetch restarts at RESET_PC.
